// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
package brq_pkg;

  localparam int unsigned   DEPTH_DEF = 8;
  localparam int unsigned   TAG_W_DEF = 3;
  localparam logic [31:0]   PC_STEP   = 32'd4;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        act_taken;
    logic [31:0] act_target;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Dispatch / execute / predictor-facing signal bundle for branch_resolve_queue.
interface branch_resolve_queue_if #(
  parameter int unsigned TAG_W = 3
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [31:0]      alloc_pc;
  logic             alloc_pred_taken;
  logic [31:0]      alloc_pred_target;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             commit_en;
  logic             flush;
  logic             branch_commit;
  logic [31:0]      pc_head;
  logic             direct_resolved;
  logic [31:0]      pc_resolved;
  logic             direct_mispredict;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [TAG_W:0]   occupancy;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
           res_valid, res_tag, res_taken, res_target, commit_en, flush,
    input  alloc_ready, alloc_tag, branch_commit, pc_head, direct_resolved,
           pc_resolved, direct_mispredict, redirect_valid, redirect_pc, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
           res_valid, res_tag, res_taken, res_target, commit_en, flush,
    output alloc_ready, alloc_tag, branch_commit, pc_head, direct_resolved,
           pc_resolved, direct_mispredict, redirect_valid, redirect_pc, occupancy
  );
endinterface

// File: rtl/brq_mispredict_chk.sv
// Compares a branch prediction against its resolution; yields mispredict and next PC.
module brq_mispredict_chk
  import brq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  input  logic        i_act_taken,
  input  logic [31:0] i_act_target,
  output logic        o_mis,
  output logic [31:0] o_next_pc
);
  always_comb begin
    o_mis     = (i_pred_taken != i_act_taken) ||
                (i_act_taken && (i_pred_target != i_act_target));
    o_next_pc = i_act_taken ? i_act_target : (i_pc + PC_STEP);
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of predicted branches: out-of-order resolve, in-order retire, squash on mispredict.
// Optional macro BRQ_RES_BYPASS_EN lets a same-cycle resolution of the head retire immediately.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_queue_if.slave bus
);
  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  brq_entry_t       r_ent [DEPTH];
  logic [TAG_W:0]   r_head, r_tail;

  logic [TAG_W-1:0] w_head_idx, w_tail_idx;
  logic             w_full, w_head_ok, w_mis, w_squash, w_alloc;
  logic             w_act_taken;
  logic [31:0]      w_act_target, w_next_pc;
  brq_entry_t       w_hd;

  assign w_head_idx = r_head[TAG_W-1:0];
  assign w_tail_idx = r_tail[TAG_W-1:0];
  assign w_full     = (r_head[TAG_W] != r_tail[TAG_W]) && (w_head_idx == w_tail_idx);
  assign w_hd       = r_ent[w_head_idx];

`ifdef BRQ_RES_BYPASS_EN
  logic w_byp;
  assign w_byp        = bus.res_valid && (bus.res_tag == w_head_idx) && w_hd.valid && bus.commit_en;
  assign w_act_taken  = w_byp ? bus.res_taken  : w_hd.act_taken;
  assign w_act_target = w_byp ? bus.res_target : w_hd.act_target;
  assign w_head_ok    = (w_hd.valid && w_hd.resolved && bus.commit_en) || w_byp;
`else
  assign w_act_taken  = w_hd.act_taken;
  assign w_act_target = w_hd.act_target;
  assign w_head_ok    = w_hd.valid && w_hd.resolved && bus.commit_en;
`endif

  brq_mispredict_chk u_chk (
    .i_pc          (w_hd.pc),
    .i_pred_taken  (w_hd.pred_taken),
    .i_pred_target (w_hd.pred_target),
    .i_act_taken   (w_act_taken),
    .i_act_target  (w_act_target),
    .o_mis         (w_mis),
    .o_next_pc     (w_next_pc)
  );

  assign w_squash        = w_head_ok && w_mis;
  assign bus.alloc_ready = !w_full && !w_squash && !bus.flush;
  assign bus.alloc_tag   = w_tail_idx;
  assign bus.occupancy   = r_tail - r_head;
  assign w_alloc         = bus.alloc_valid && bus.alloc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent[i[TAG_W-1:0]].valid    <= 1'b0;
        r_ent[i[TAG_W-1:0]].resolved <= 1'b0;
      end
      r_head                <= '0;
      r_tail                <= '0;
      bus.branch_commit     <= 1'b0;
      bus.pc_head           <= '0;
      bus.direct_resolved   <= 1'b0;
      bus.pc_resolved       <= '0;
      bus.direct_mispredict <= 1'b0;
      bus.redirect_valid    <= 1'b0;
      bus.redirect_pc       <= '0;
    end else begin
      bus.branch_commit  <= 1'b0;
      bus.redirect_valid <= 1'b0;
      if (bus.flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_ent[i[TAG_W-1:0]].valid <= 1'b0;
        r_tail <= r_head;
      end else begin
        // Resolve first so that a retiring head's invalidation below takes precedence.
        if (!w_squash && bus.res_valid && r_ent[bus.res_tag].valid) begin
          r_ent[bus.res_tag].resolved   <= 1'b1;
          r_ent[bus.res_tag].act_taken  <= bus.res_taken;
          r_ent[bus.res_tag].act_target <= bus.res_target;
        end
        if (w_head_ok) begin
          bus.branch_commit     <= 1'b1;
          bus.pc_head           <= w_hd.pc;
          bus.direct_resolved   <= w_act_taken;
          bus.pc_resolved       <= w_next_pc;
          bus.direct_mispredict <= w_mis;
          r_ent[w_head_idx].valid <= 1'b0;
          r_head                  <= r_head + PTR_ONE;
        end
        if (w_squash) begin
          for (int unsigned i = 0; i < DEPTH; i++) r_ent[i[TAG_W-1:0]].valid <= 1'b0;
          r_tail             <= r_head + PTR_ONE;
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= w_next_pc;
        end else if (w_alloc) begin
          r_ent[w_tail_idx] <= '{valid: 1'b1, resolved: 1'b0, pc: bus.alloc_pc,
                                 pred_taken: bus.alloc_pred_taken,
                                 pred_target: bus.alloc_pred_target,
                                 act_taken: 1'b0, act_target: '0};
          r_tail <= r_tail + PTR_ONE;
        end
      end
    end
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracker for in-flight predicted branches. It sits between fetch/dispatch, the branch execute unit, and the branch predictor.
- Each predicted branch is allocated an entry holding its PC and prediction. The execute unit resolves entries out of order, by tag.
- The queue retires entries strictly in order and drives the predictor's commit/update inputs (branch_commit, pc_head, direct_resolved, pc_resolved, direct_mispredict).
- On a mispredict it raises a fetch redirect and squashes all younger entries.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- TAG_W, 3, tag width; equals log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- alloc_valid  in  1  dispatch presents a predicted branch.
- alloc_ready  out  1  entry available; allocation occurs when alloc_valid && alloc_ready.
- alloc_pc  in  32  branch PC.
- alloc_pred_taken  in  1  predicted direction.
- alloc_pred_target  in  32  predicted target (BTB output).
- alloc_tag  out  TAG_W  tag assigned to the current allocation (equals the tail index).
- res_valid  in  1  execute unit resolves a branch.
- res_tag  in  TAG_W  tag being resolved.
- res_taken  in  1  actual direction.
- res_target  in  32  actual target.
- commit_en  in  1  retirement permitted this cycle (ROB head is a branch).
- flush  in  1  external pipeline flush (exception).
- branch_commit  out  1  one-cycle pulse: head entry retired.
- pc_head  out  32  PC of the retiring branch.
- direct_resolved  out  1  actual direction of the retiring branch.
- pc_resolved  out  32  actual target of the retiring branch.
- direct_mispredict  out  1  retiring branch was mispredicted.
- redirect_valid  out  1  fetch redirect pulse.
- redirect_pc  out  32  redirect address.
- occupancy  out  TAG_W+1  valid entry count.

Behaviour:
- Storage and reset:
  - Circular buffer. Head and tail pointers are TAG_W+1 bits wide; the extra bit distinguishes full from empty.
  - Per-entry fields: valid, resolved, pc, pred_taken, pred_target, act_taken, act_target.
  - rst: all valid/resolved bits cleared, pointers 0, every output 0. A rst asserted mid-operation discards all entries with no commit pulse.
- Allocation:
  - alloc_ready = !full && !squash_now && !flush.
  - On allocation: entry[tail] is written with valid=1, resolved=0; tail increments, wrapping modulo 2*DEPTH.
  - alloc_tag is combinational and equals tail[TAG_W-1:0].
- Resolution:
  - When res_valid and entry[res_tag] is valid: the entry's act_taken/act_target are written and resolved=1.
  - A resolution to an invalid entry is ignored.
  - A resolution to an already-resolved entry overwrites it.
- Retirement:
  - head_ok = entry[head].valid && entry[head].resolved && commit_en.
  - mis = pred_taken != act_taken, OR (act_taken && pred_target != act_target).
  - When head_ok, at the next edge:
    - outputs are registered: branch_commit=1, pc_head=pc, direct_resolved=act_taken, pc_resolved = act_taken ? act_target : pc+4, direct_mispredict=mis;
    - the head entry is invalidated and head increments.
  - Latency: res_valid on the head in cycle N sets resolved at N+1; commit pulse at N+2 if commit_en is high in N+1.
  - All commit and redirect outputs are one-cycle pulses and are 0 otherwise. Data outputs hold their last value.
- Mispredict: squash_now = head_ok && mis (combinational). At the commit edge:
  - all entries are invalidated and tail=head+1, so the queue is empty;
  - redirect_valid=1 and redirect_pc=pc_resolved in the same cycle as branch_commit;
  - any allocation or resolution in the squash cycle is dropped.
- flush:
  - Highest priority after rst. At the next edge all entries are invalidated and tail=head.
  - No commit pulse and no redirect are produced.
  - A simultaneous head_ok commit is suppressed.
- Simultaneous events:
  - Allocation and non-mispredict retirement in the same cycle: both take effect, occupancy unchanged.
  - A full queue with a retirement in the same cycle still reports alloc_ready=0; no same-cycle slot reuse.
- Arithmetic: pc+4 is computed modulo 2^32.

Optional Feature:
- Macro: BRQ_RES_BYPASS_EN.
- Defined: if res_valid targets the head tag in cycle N and commit_en is high in N, the head retires at the N edge using the res_* values directly. The commit pulse appears at N+1, and the mispredict/squash rules apply identically.
- Undefined: standard 2-cycle resolve-to-commit latency; no bypass logic is built.

Decomposition:
- brq_pkg holds:
  - the brq_entry_t packed struct (valid, resolved, pc, pred_taken, pred_target, act_taken, act_target);
  - the DEPTH/TAG_W defaults;
  - the PC_STEP=4 constant.
- One sub-module, brq_mispredict_chk: combinational compare of prediction against resolution, outputs mis and the next pc.

Test Plan:
- After rst, alloc pc=0x100 pred_taken=1 target=0x200, resolve taken=1 target=0x200 with commit_en=1 -> branch_commit pulse 2 cycles after resolve; pc_head=0x100, pc_resolved=0x200, direct_mispredict=0, no redirect.
- Alloc tags 0,1,2 (pcs 0x10, 0x20, 0x30); resolve tag 2, then 1, then 0 -> commits in order 0x10, 0x20, 0x30, one per cycle.
- Alloc 0x40 (pred_taken=0) and 0x44; resolve 0x40 taken target 0x80 -> direct_mispredict=1, redirect_pc=0x80, occupancy=0 next cycle; later resolve of the squashed tag is ignored.
- Alloc 8 entries -> alloc_ready=0 with occupancy=8; tail wraps after head retires; tag reuse is correct.
- flush with 3 valid, resolved entries and commit_en=1 -> no branch_commit, occupancy=0, alloc_ready=1 next cycle.
- With BRQ_RES_BYPASS_EN: resolve the head in cycle N with commit_en=1 -> branch_commit in N+1.
